wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone arbiter for the user-project memory port. Master 0 is the
//  CPU path (Caravel wbs_* decoded to memory); master 1 is the DMA engine's master port.
//  Grants are round-robin. DMA bursts are capped, and stalled slave accesses are time-limited,
//  so neither master can starve the other or hang the bus.
// PARAMETERS
//  MAX_BURST       8   acks a master may take back-to-back while the other master waits (>=1)
//  TIMEOUT_CYCLES  64  cycles of mem_stb_o without mem_ack_i before the access is aborted (>=2)
// PORTS
//  wb_clk_i     in   1   single clock; all state on rising edge
//  wb_rst_i     in   1   reset, synchronous, active-high
//  cpu_cyc_i    in   1   M0 cycle request
//  cpu_stb_i    in   1   M0 strobe
//  cpu_we_i     in   1   M0 write enable
//  cpu_sel_i    in   4   M0 byte selects
//  cpu_adr_i    in   32  M0 address
//  cpu_dat_i    in   32  M0 write data
//  cpu_dat_o    out  32  M0 read data (= mem_dat_i)
//  cpu_ack_o    out  1   M0 ack
//  cpu_err_o    out  1   M0 timeout error
//  dma_cyc_i/dma_stb_i/dma_we_i/dma_sel_i/dma_adr_i/dma_dat_i  in  1/1/1/4/32/32  M1 bus, same as M0
//  dma_dat_o    out  32  M1 read data (= mem_dat_i)
//  dma_ack_o    out  1   M1 ack
//  dma_err_o    out  1   M1 timeout error
//  mem_cyc_o/mem_stb_o/mem_we_o/mem_sel_o/mem_adr_o/mem_dat_o  out  1/1/1/4/32/32  slave bus
//  mem_dat_i    in   32  slave read data
//  mem_ack_i    in   1   slave ack
//  grant_o      out  2   2'b00 idle, 2'b01 CPU, 2'b10 DMA (registered state)
// BEHAVIOUR
//  - FSM states: IDLE, GNT_CPU, GNT_DMA. Also registered: last_gnt (1b), beat_cnt, to_cnt.
//  - Reset: state=IDLE, last_gnt=DMA (CPU wins the first tie), beat_cnt=0, to_cnt=0.
//    All mem_* outputs, acks and errs read 0. grant_o=00. dat_o outputs follow mem_dat_i.
//  - Request: req_x = x_cyc_i & x_stb_i.
//  - IDLE: one request -> grant it. Both -> grant the master != last_gnt. None -> stay IDLE.
//    Arbitration latency: request in cycle N gives grant and mem_stb_o in cycle N+1.
//  - Granted state: mem_* = granted master's signals, muxed combinationally from the
//    registered state. mem_stb_o = cyc_i & stb_i of the granted master.
//    x_ack_o = granted(x) & mem_ack_i. The non-granted master never sees ack or err.
//  - beat_cnt: +1 on each mem_ack_i; cleared on any grant change.
//  - to_cnt: +1 each cycle mem_stb_o=1 and mem_ack_i=0; cleared on ack, on grant change,
//    and while stb is low.
//  - Timeout: to_cnt==TIMEOUT_CYCLES-1 and mem_ack_i=0 -> x_err_o=1 for that cycle
//    (combinational). The grant is released at the edge.
//  - Ack and timeout in the same cycle: ack wins; no err.
//  - Release (evaluated at the edge while granted), any of:
//    (a) granted cyc_i=0;
//    (b) mem_ack_i=1 and beat_cnt+1==MAX_BURST and the other master requests;
//    (c) timeout.
//    On release: last_gnt <= released master. Next state = GNT_other if the other requests
//    (direct hand-over, no idle cycle), else IDLE.
//  - Without a release, the grant holds across stb gaps while cyc stays high.
//    beat_cnt saturates at MAX_BURST when the other master is not requesting.
//  - A master dropping cyc mid-access is legal: its stb is masked at once (mem_stb_o follows
//    stb_i), and the grant drops at the next edge.
//  - Reset mid-transfer: next edge forces IDLE. The in-flight access is abandoned, and any
//    slave ack arriving afterwards is ignored.
// TESTING
//  - Reset, then CPU read 0x3800_0010, slave acks 2 cycles later -> grant_o=01 the cycle after
//    req; cpu_ack_o for 1 cycle with mem_dat_i; dma_ack_o=0 throughout.
//  - CPU and DMA request in the same cycle after reset -> CPU granted first. CPU drops cyc
//    after 1 ack -> next edge grant_o=10, no IDLE cycle between.
//  - DMA holds cyc for 20 zero-wait acks while CPU requests (MAX_BURST=8) -> DMA released after
//    8th ack; CPU gets 1 access; DMA regranted; pattern repeats.
//  - DMA burst of 20 with CPU idle -> DMA never released; 20 acks all to DMA.
//  - Slave never acks a DMA write (TIMEOUT_CYCLES=64) -> dma_err_o=1 exactly on the 64th stb
//    cycle; grant released at the next edge. Repeat with ack on the 64th cycle -> ack, no err.
//  - Assert wb_rst_i for 1 cycle during a GNT_DMA access -> grant_o=00 and mem_cyc_o=0 after
//    the edge; a late mem_ack_i produces no master ack.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master (CPU, DMA), one-slave Wishbone arbiter for the
// user-project memory port. Round-robin grants, capped back-to-back bursts and
// a stalled-access timeout keep either master from starving the other or
// hanging the bus.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cpu_*_i / cpu_*_o           master 0 (CPU) Wishbone slave-side port
//   dma_*_i / dma_*_o           master 1 (DMA) Wishbone slave-side port
//   mem_*_o / mem_*_i           Wishbone master-side port to the memory
//   grant_o                     00 idle, 01 CPU, 10 DMA (registered state)
module wb_mem_arbiter #(
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  input  logic        dma_cyc_i,
  input  logic        dma_stb_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_sel_i,
  input  logic [31:0] dma_adr_i,
  input  logic [31:0] dma_dat_i,
  output logic [31:0] dma_dat_o,
  output logic        dma_ack_o,
  output logic        dma_err_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic [1:0]  grant_o
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GNT_CPU = 2'b01;
  localparam logic [1:0] GNT_DMA = 2'b10;

  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_DMA = 1'b1;

  logic [1:0]        state, state_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;

  logic req_cpu, req_dma;
  logic gnt_cpu, gnt_dma;
  logic timeout_c;
  logic burst_done_c;

  assign req_cpu = cpu_cyc_i & cpu_stb_i;
  assign req_dma = dma_cyc_i & dma_stb_i;
  assign gnt_cpu = (state == GNT_CPU);
  assign gnt_dma = (state == GNT_DMA);

  assign grant_o   = state;
  assign cpu_dat_o = mem_dat_i;
  assign dma_dat_o = mem_dat_i;

  // Slave bus follows the granted master; stb masked by that master's cyc
  always_comb begin
    mem_cyc_o = 1'b0;
    mem_stb_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_sel_o = 4'h0;
    mem_adr_o = 32'h0;
    mem_dat_o = 32'h0;
    if (gnt_cpu) begin
      mem_cyc_o = cpu_cyc_i;
      mem_stb_o = cpu_cyc_i & cpu_stb_i;
      mem_we_o  = cpu_we_i;
      mem_sel_o = cpu_sel_i;
      mem_adr_o = cpu_adr_i;
      mem_dat_o = cpu_dat_i;
    end else if (gnt_dma) begin
      mem_cyc_o = dma_cyc_i;
      mem_stb_o = dma_cyc_i & dma_stb_i;
      mem_we_o  = dma_we_i;
      mem_sel_o = dma_sel_i;
      mem_adr_o = dma_adr_i;
      mem_dat_o = dma_dat_i;
    end
  end

  // Ack beats a simultaneous timeout; to_cnt is only meaningful while stb is high
  assign timeout_c = (state != IDLE) & mem_stb_o & ~mem_ack_i &
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  assign burst_done_c = mem_ack_i & ((32'(beat_cnt) + 32'd1) == MAX_BURST);

  assign cpu_ack_o = gnt_cpu & mem_ack_i;
  assign dma_ack_o = gnt_dma & mem_ack_i;
  assign cpu_err_o = gnt_cpu & timeout_c;
  assign dma_err_o = gnt_dma & timeout_c;

  // Next-state: round-robin arbitration and release with direct hand-over
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (req_cpu && req_dma) begin
          state_nxt = (last_gnt == LAST_DMA) ? GNT_CPU : GNT_DMA;
        end else if (req_cpu) begin
          state_nxt = GNT_CPU;
        end else if (req_dma) begin
          state_nxt = GNT_DMA;
        end
      end
      GNT_CPU: begin
        if (!cpu_cyc_i || (burst_done_c && req_dma) || timeout_c) begin
          last_gnt_nxt = LAST_CPU;
          state_nxt    = req_dma ? GNT_DMA : IDLE;
        end
      end
      GNT_DMA: begin
        if (!dma_cyc_i || (burst_done_c && req_cpu) || timeout_c) begin
          last_gnt_nxt = LAST_DMA;
          state_nxt    = req_cpu ? GNT_CPU : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst and timeout counters, both cleared on any grant change
  always_comb begin
    beat_nxt = beat_cnt;
    to_nxt   = to_cnt;
    if (state_nxt != state) begin
      beat_nxt = '0;
      to_nxt   = '0;
    end else if (state != IDLE) begin
      if (mem_ack_i && (beat_cnt != BEAT_W'(MAX_BURST))) begin
        beat_nxt = beat_cnt + BEAT_W'(1);
      end
      if (mem_ack_i || !mem_stb_o) begin
        to_nxt = '0;
      end else begin
        to_nxt = to_cnt + TO_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      last_gnt <= LAST_DMA;
      beat_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_nxt;
      to_cnt   <= to_nxt;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed bench for wb_mem_arbiter (MAX_BURST=8,
// TIMEOUT_CYCLES=64). Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 unit later, well before the next edge.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic        cpu_ack_o, cpu_err_o;
  logic        dma_cyc_i, dma_stb_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i, dma_dat_o;
  logic        dma_ack_o, dma_err_o;
  logic        mem_cyc_o, mem_stb_o, mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
  logic        mem_ack_i;
  logic [1:0]  grant_o;

  logic auto_ack;
  logic man_ack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Zero-wait slave when auto_ack is set, otherwise hand-driven ack
  assign mem_ack_i = auto_ack ? mem_stb_o : man_ack;

  wb_mem_arbiter #(.MAX_BURST(8), .TIMEOUT_CYCLES(64)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_dat_o(dma_dat_o), .dma_ack_o(dma_ack_o), .dma_err_o(dma_err_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .grant_o  (grant_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
    cpu_sel_i = 4'h0; cpu_adr_i = 32'h0; cpu_dat_i = 32'h0;
    dma_cyc_i = 1'b0; dma_stb_i = 1'b0; dma_we_i = 1'b0;
    dma_sel_i = 4'h0; dma_adr_i = 32'h0; dma_dat_i = 32'h0;
    auto_ack  = 1'b0; man_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    wb_rst_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;
  endtask

  task automatic dma_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_we_i = we;
    dma_sel_i = 4'hF; dma_adr_i = adr; dma_dat_i = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dma_n;
    int cpu_n;
    int bad;
    int err_n;
    logic [63:0] seq;
    logic both;
    logic cpu_pause;

    idle_inputs();
    mem_dat_i = 32'h0;
    wb_rst_i  = 1'b1;
    tick();
    tick();

    // Reset state
    mem_dat_i = 32'h1234_5678;
    #1;
    check("rst_grant",   64'(grant_o),   64'd0);
    check("rst_mem_cyc", 64'(mem_cyc_o), 64'd0);
    check("rst_mem_stb", 64'(mem_stb_o), 64'd0);
    check("rst_acks",    64'({cpu_ack_o, dma_ack_o}), 64'd0);
    check("rst_errs",    64'({cpu_err_o, dma_err_o}), 64'd0);
    check("rst_cpu_dat", 64'(cpu_dat_o), 64'h1234_5678);
    check("rst_dma_dat", 64'(dma_dat_o), 64'h1234_5678);
    wb_rst_i = 1'b0;
    tick();

    // CPU read, slave acks two cycles after the request
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0;
    cpu_sel_i = 4'hF; cpu_adr_i = 32'h3800_0010;
    #1;
    check("t1_req_grant", 64'(grant_o),   64'd0);
    check("t1_req_stb",   64'(mem_stb_o), 64'd0);
    tick();
    #1;
    check("t1_grant",  64'(grant_o),   64'd1);
    check("t1_stb",    64'(mem_stb_o), 64'd1);
    check("t1_adr",    64'(mem_adr_o), 64'h3800_0010);
    check("t1_we",     64'(mem_we_o),  64'd0);
    check("t1_noack",  64'(cpu_ack_o), 64'd0);
    tick();
    man_ack = 1'b1; mem_dat_i = 32'hCAFE_0001;
    #1;
    check("t1_ack",     64'(cpu_ack_o), 64'd1);
    check("t1_dat",     64'(cpu_dat_o), 64'hCAFE_0001);
    check("t1_dma_ack", 64'(dma_ack_o), 64'd0);
    check("t1_err",     64'(cpu_err_o), 64'd0);
    tick();
    man_ack = 1'b0; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    #1;
    check("t1_ack_gone",  64'(cpu_ack_o), 64'd0);
    check("t1_hold_gnt",  64'(grant_o),   64'd1);
    check("t1_cyc_mask",  64'(mem_cyc_o), 64'd0);
    tick();
    #1;
    check("t1_idle", 64'(grant_o), 64'd0);

    // Simultaneous requests: CPU first, then direct hand-over to DMA
    do_reset();
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_sel_i = 4'hF; cpu_adr_i = 32'h3800_0100;
    dma_req(1'b1, 32'h3800_0200, 32'hD00D_0002);
    #1;
    check("t2_idle", 64'(grant_o), 64'd0);
    tick();
    auto_ack = 1'b1;
    #1;
    check("t2_gnt_cpu", 64'(grant_o),   64'd1);
    check("t2_cpu_adr", 64'(mem_adr_o), 64'h3800_0100);
    check("t2_cpu_ack", 64'({cpu_ack_o, dma_ack_o}), 64'b10);
    tick();
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    #1;
    check("t2_cpu_drop", 64'(grant_o),   64'd1);
    check("t2_no_acks",  64'({cpu_ack_o, dma_ack_o}), 64'b00);
    tick();
    #1;
    check("t2_gnt_dma", 64'(grant_o),   64'd2);
    check("t2_dma_adr", 64'(mem_adr_o), 64'h3800_0200);
    check("t2_dma_wr",  64'({mem_we_o, mem_dat_o}), {31'd0, 1'b1, 32'hD00D_0002});
    check("t2_dma_ack", 64'({cpu_ack_o, dma_ack_o}), 64'b01);
    idle_inputs();
    tick();
    #1;
    check("t2_end_idle", 64'(grant_o), 64'd0);

    // DMA 20-beat burst with CPU competing: 8 DMA, 1 CPU, 8 DMA, 1 CPU, 4 DMA
    do_reset();
    auto_ack = 1'b1;
    dma_req(1'b0, 32'h3800_1000, 32'h0);
    tick();
    dma_n = 0; cpu_n = 0; seq = 64'd0; both = 1'b0; cpu_pause = 1'b0;
    for (int c = 1; c < 60 && dma_n < 20; c++) begin
      cpu_cyc_i = ~cpu_pause; cpu_stb_i = ~cpu_pause; cpu_pause = 1'b0;
      #1;
      if (cpu_ack_o && dma_ack_o) both = 1'b1;
      if (dma_ack_o) begin seq = {seq[62:0], 1'b0}; dma_n++; end
      if (cpu_ack_o) begin seq = {seq[62:0], 1'b1}; cpu_n++; cpu_pause = 1'b1; end
      tick();
    end
    idle_inputs();
    check("t3_dma_acks", 64'(dma_n), 64'd20);
    check("t3_cpu_acks", 64'(cpu_n), 64'd2);
    check("t3_order",    seq,        64'h2010);
    check("t3_no_both",  64'(both),  64'd0);
    tick();

    // DMA 20-beat burst with CPU idle: never released
    do_reset();
    auto_ack = 1'b1;
    dma_req(1'b0, 32'h3800_2000, 32'h0);
    tick();
    dma_n = 0; cpu_n = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dma_ack_o) dma_n++;
      if (cpu_ack_o) cpu_n++;
      if (grant_o != 2'b10) bad++;
      tick();
    end
    #1;
    check("t4_dma_acks", 64'(dma_n),   64'd20);
    check("t4_cpu_acks", 64'(cpu_n),   64'd0);
    check("t4_released", 64'(bad),     64'd0);
    check("t4_still",    64'(grant_o), 64'd2);
    idle_inputs();
    tick();

    // DMA write never acked: err on the 64th stb cycle, then release
    do_reset();
    dma_req(1'b1, 32'h3800_3000, 32'h5555_AAAA);
    tick();
    err_n = 0;
    for (int k = 1; k <= 64; k++) begin
      #1;
      if (dma_err_o) err_n++;
      if (k == 63) check("t5_err63", 64'(dma_err_o), 64'd0);
      if (k == 64) begin
        check("t5_err64",  64'(dma_err_o), 64'd1);
        check("t5_cpuerr", 64'(cpu_err_o), 64'd0);
      end
      tick();
    end
    #1;
    check("t5_err_count", 64'(err_n),   64'd1);
    check("t5_release",   64'(grant_o), 64'd0);
    idle_inputs();
    tick();

    // Same, but the slave acks on the 64th cycle: ack wins, no err
    do_reset();
    dma_req(1'b1, 32'h3800_3004, 32'h5555_AAAB);
    tick();
    err_n = 0;
    for (int k = 1; k <= 64; k++) begin
      if (k == 64) man_ack = 1'b1;
      #1;
      if (dma_err_o) err_n++;
      if (k == 64) check("t5b_ack64", 64'(dma_ack_o), 64'd1);
      tick();
    end
    man_ack = 1'b0;
    #1;
    check("t5b_err_count", 64'(err_n),     64'd0);
    check("t5b_hold",      64'(grant_o),   64'd2);
    check("t5b_no_err",    64'(dma_err_o), 64'd0);
    idle_inputs();
    tick();

    // Reset during a stalled DMA access; late ack ignored
    do_reset();
    dma_req(1'b0, 32'h3800_4000, 32'h0);
    tick();
    #1;
    check("t6_gnt",     64'(grant_o),   64'd2);
    check("t6_mem_cyc", 64'(mem_cyc_o), 64'd1);
    tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    man_ack  = 1'b1;
    #1;
    check("t6_rst_gnt", 64'(grant_o),   64'd0);
    check("t6_rst_cyc", 64'(mem_cyc_o), 64'd0);
    check("t6_late_ack", 64'({cpu_ack_o, dma_ack_o}), 64'd0);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
